// File: rtl/countdown_timer.sv
// Loadable down-counter with run/hold control, a terminal-count pulse and optional auto-reload.
// The count moves only on enabled ticks while in RUN.
module countdown_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             ld,
   input  logic [WIDTH-1:0] v,
   input  logic             start,
   input  logic             stop,
   input  logic             reload,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] count_n;
   logic [WIDTH-1:0] rv, rv_n;
   logic             done_n;

   assign zero = (count == '0);

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         rv    <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         count <= count_n;
         rv    <= rv_n;
         busy  <= (state_n == RUN);
         done  <= done_n;
      end
   end

   // Next-state logic; ld overrides everything, then stop, then start, then the tick
   always_comb begin
      state_n = state;
      count_n = count;
      rv_n    = rv;
      done_n  = 1'b0;
      if (ld) begin
         count_n = v;
         rv_n    = v;
         state_n = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (!stop && start && (count != '0)) begin
                  state_n = RUN;
               end
            end
            RUN: begin
               if (stop) begin
                  state_n = HOLD;
               end else if (en) begin
                  if (count > WIDTH'(1)) begin
                     count_n = count - WIDTH'(1);
                  end else if (count == WIDTH'(1)) begin
                     done_n = 1'b1;
                     if (reload && (rv != '0)) begin
                        count_n = rv;
                     end else begin
                        count_n = '0;
                        state_n = IDLE;
                     end
                  end else begin
                     state_n = IDLE;
                  end
               end
            end
            HOLD: begin
               if (stop) begin
                  state_n = IDLE;
               end else if (start) begin
                  state_n = RUN;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: each task drives one scenario and checks outputs inline.
module tb_countdown_timer;

   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst, en, ld, start, stop, reload;
   logic [WIDTH-1:0] v;
   logic [WIDTH-1:0] count;
   logic             busy, done, zero;

   int tests = 0;
   int fails = 0;

   countdown_timer #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .en(en), .ld(ld), .v(v), .start(start),
      .stop(stop), .reload(reload), .count(count), .busy(busy),
      .done(done), .zero(zero)
   );

   always #5 clk = ~clk;

   // One clock edge; outputs are looked at 1ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 1'b0; en = 1'b0; ld = 1'b0; start = 1'b0; stop = 1'b0; reload = 1'b0; v = '0;
   endtask

   task automatic load(input logic [WIDTH-1:0] val);
      ld = 1'b1; v = val; step(); ld = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; ld = 1'b1; v = 8'd55; start = 1'b1; en = 1'b1;
      step(); step();
      idle_inputs();
      tests++;
      if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || zero !== 1'b1) begin
         fails++;
         $display("FAIL reset: count=%0d busy=%b done=%b zero=%b, want 0 0 0 1", count, busy, done, zero);
      end
   endtask

   task automatic test_one_shot();
      logic [WIDTH-1:0] exp_c [4] = '{8'd3, 8'd2, 8'd1, 8'd0};
      load(8'd3);
      en = 1'b1; start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (count !== exp_c[i] || busy !== (i < 3) || done !== (i == 3)) begin
            fails++;
            $display("FAIL one_shot[%0d]: count=%0d busy=%b done=%b, want %0d %b %b",
                     i, count, busy, done, exp_c[i], i < 3, i == 3);
         end
         if (i < 3) step();
      end
      step();
      tests++;
      if (done !== 1'b0 || count !== 8'd0 || zero !== 1'b1) begin
         fails++;
         $display("FAIL one_shot_after: done=%b count=%0d zero=%b, want 0 0 1", done, count, zero);
      end
      en = 1'b0;
   endtask

   task automatic test_tick_gating();
      logic       en_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [7:0] exp_c  [7] = '{8'd3, 8'd3, 8'd3, 8'd2, 8'd1, 8'd1, 8'd0};
      int         dones = 0;
      load(8'd4);
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         en = en_pat[i]; step();
         if (done === 1'b1) dones++;
         tests++;
         if (count !== exp_c[i]) begin
            fails++;
            $display("FAIL tick_gating[%0d]: count=%0d, want %0d", i, count, exp_c[i]);
         end
      end
      en = 1'b0; step();
      tests++;
      if (dones != 1 || done !== 1'b0) begin
         fails++;
         $display("FAIL tick_gating_done: pulses=%0d done=%b, want 1 0", dones, done);
      end
   endtask

   task automatic test_auto_reload();
      load(8'd2);
      reload = 1'b1; en = 1'b1; start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         tests++;
         if (count !== ((i % 2 == 0) ? 8'd1 : 8'd2) || done !== (i % 2 == 1) || busy !== 1'b1) begin
            fails++;
            $display("FAIL auto_reload[%0d]: count=%0d done=%b busy=%b, want %0d %b 1",
                     i, count, done, busy, (i % 2 == 0) ? 1 : 2, i % 2 == 1);
         end
      end
      reload = 1'b0;
      step(); step();
      tests++;
      if (count !== 8'd0 || done !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reload_cleared: count=%0d done=%b busy=%b, want 0 1 0", count, done, busy);
      end
      en = 1'b0;
   endtask

   task automatic test_pause_abort();
      load(8'd10);
      start = 1'b1; step(); start = 1'b0;
      en = 1'b1;
      for (int i = 0; i < 5; i++) step();
      stop = 1'b1; step(); stop = 1'b0;
      tests++;
      if (count !== 8'd5 || busy !== 1'b0) begin
         fails++;
         $display("FAIL pause_enter: count=%0d busy=%b, want 5 0", count, busy);
      end
      for (int i = 0; i < 4; i++) step();
      tests++;
      if (count !== 8'd5 || busy !== 1'b0) begin
         fails++;
         $display("FAIL pause_hold: count=%0d busy=%b, want 5 0", count, busy);
      end
      en = 1'b0; stop = 1'b1; step(); stop = 1'b0;
      en = 1'b1; step();
      tests++;
      if (count !== 8'd5 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL abort_idle: count=%0d busy=%b done=%b, want 5 0 0", count, busy, done);
      end
      start = 1'b1; step(); start = 1'b0;
      tests++;
      if (count !== 8'd5 || busy !== 1'b1) begin
         fails++;
         $display("FAIL resume_start: count=%0d busy=%b, want 5 1", count, busy);
      end
      step();
      tests++;
      if (count !== 8'd4) begin
         fails++;
         $display("FAIL resume_tick: count=%0d, want 4", count);
      end
      en = 1'b0;
   endtask

   task automatic test_full_scale();
      int n = 0;
      int done_at = -1;
      load(8'd255);
      start = 1'b1; step(); start = 1'b0;
      en = 1'b1;
      while (done_at < 0 && n < 300) begin
         step(); n++;
         if (done === 1'b1) done_at = n;
      end
      en = 1'b0;
      tests++;
      if (done_at != 255 || count !== 8'd0) begin
         fails++;
         $display("FAIL full_scale: done after %0d ticks count=%0d, want 255 0", done_at, count);
      end
   endtask

   task automatic test_back_to_back();
      load(8'd5);
      start = 1'b1; step(); start = 1'b0;
      en = 1'b1; step(); step(); step();
      tests++;
      if (count !== 8'd2) begin
         fails++;
         $display("FAIL ld_mid_setup: count=%0d, want 2", count);
      end
      ld = 1'b1; v = 8'd7; step(); ld = 1'b0;
      tests++;
      if (count !== 8'd7 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL ld_mid_run: count=%0d busy=%b done=%b, want 7 0 0", count, busy, done);
      end
      step(); step();
      tests++;
      if (count !== 8'd7 || done !== 1'b0) begin
         fails++;
         $display("FAIL ld_mid_after: count=%0d done=%b, want 7 0", count, done);
      end
      // rv=1 with reload pulses done every cycle
      load(8'd1);
      reload = 1'b1; start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         tests++;
         if (done !== 1'b1 || count !== 8'd1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL reload_rv1[%0d]: done=%b count=%0d busy=%b, want 1 1 1", i, done, count, busy);
         end
      end
      reload = 1'b0; en = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      load(8'd2);
      start = 1'b1; step(); start = 1'b0;
      en = 1'b1; step();
      rst = 1'b1; step(); rst = 1'b0;
      tests++;
      if (count !== 8'd0 || done !== 1'b0 || busy !== 1'b0 || zero !== 1'b1) begin
         fails++;
         $display("FAIL rst_mid_run: count=%0d done=%b busy=%b zero=%b, want 0 0 0 1", count, done, busy, zero);
      end
      step();
      tests++;
      if (done !== 1'b0 || count !== 8'd0) begin
         fails++;
         $display("FAIL rst_mid_after: done=%b count=%0d, want 0 0", done, count);
      end
      en = 1'b0;
   endtask

   task automatic test_start_zero();
      load(8'd0);
      tests++;
      if (zero !== 1'b1) begin
         fails++;
         $display("FAIL ld_zero: zero=%b, want 1", zero);
      end
      start = 1'b1; en = 1'b1; step(); start = 1'b0; step();
      tests++;
      if (busy !== 1'b0 || count !== 8'd0 || done !== 1'b0) begin
         fails++;
         $display("FAIL start_zero: busy=%b count=%0d done=%b, want 0 0 0", busy, count, done);
      end
      en = 1'b0;
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_one_shot();
      test_tick_gating();
      test_auto_reload();
      test_pause_abort();
      test_full_scale();
      test_back_to_back();
      test_reset_mid_run();
      test_start_zero();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with run/hold control, terminal-count pulse and optional auto-reload. It is the counting-down counterpart to the team's enable-gated up-counter. It shares the `en` tick convention, so one prescaler strobe can drive both blocks. It sits between a software-visible load value and any logic that needs a one-shot or periodic timeout.

## Interface
- `WIDTH`, default 8, width of the count and the load value.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  tick enable; the count moves only in cycles where `en`=1.
- `ld`  in  1  load strobe; captures `v`.
- `v`  in  WIDTH  load value.
- `start`  in  1  start or resume counting.
- `stop`  in  1  pause, or abort when already paused.
- `reload`  in  1  mode select: 1 = auto-reload on terminal count, 0 = one-shot. Sampled at each terminal count.
- `count`  out  WIDTH  current count, registered.
- `busy`  out  1  high while in RUN, registered.
- `done`  out  1  one-cycle terminal-count pulse, registered.
- `zero`  out  1  combinational, `count == 0`.

## Operation
- **Internal state:** `count`, reload register `rv` (WIDTH), FSM state ∈ {IDLE, RUN, HOLD}.
- **Priority per cycle:** `rst` > `ld` > `stop` > `start` > tick.
- **Reset:** `count`=0, `rv`=0, state=IDLE, `busy`=0, `done`=0, so `zero`=1.
- **ld (any state):** `count`←`v`, `rv`←`v`, state→IDLE. Other inputs in that cycle are ignored.
- **IDLE:**
  - `start` with `count`≠0 → RUN.
  - `start` with `count`=0 is ignored; no `done` pulse.
  - Ticks are ignored.
- **RUN, tick (`en`=1):**
  - `count`>1: `count`←`count`−1.
  - `count`=1 and `reload`=0: `count`←0, `done`←1, state→IDLE.
  - `count`=1 and `reload`=1: `count`←`rv`, `done`←1, stay RUN.
- **RUN, other inputs:**
  - `stop` → HOLD. The count does not decrement in that cycle, even with `en`=1.
  - `start` is ignored.
- **HOLD:**
  - `count` is frozen regardless of `en`.
  - `start` → RUN with no decrement in that cycle.
  - `stop` → IDLE with `count` retained.
- **No underflow:** `count` never wraps below 0. There is no arithmetic carry out.
- **Full scale:** `v` = 2^WIDTH−1 is legal. It gives 2^WIDTH−1 ticks to terminal count.

## Timing
- **Start latency:** `start` is sampled at edge N; state=RUN and `busy`=1 after N. The first decrement can occur at edge N+1, so a `start` cycle with `en`=1 does not count.
- **One-shot duration:** a run of value V needs exactly V tick cycles in RUN. `count` reaches 0 at the edge after the V-th tick.
- **done:**
  - High exactly one cycle, in the cycle after the terminal edge.
  - In one-shot mode it is concurrent with `count`=0 and `busy`=0.
  - It never asserts for two consecutive cycles except in reload mode with `rv`=1 and `en` held high. That case pulses every cycle, which is legal.
- **Reload period:** `done` fires every `rv` tick cycles.
- **Reset mid-run:** all outputs take reset values after the reset edge; any `done` not yet issued is lost.
- **ld mid-run:** the run is aborted with no `done`; `busy`=0 on the next cycle.
- **v = 0:** `ld` with `v`=0 leaves `zero`=1 and a subsequent `start` is ignored.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `ld`/`start` high → `count`=0, `busy`=0, `done`=0, `zero`=1. The `ld` value is not captured.
- **One-shot:** WIDTH=8, `ld` `v`=3, `start`, `en`=1 continuously, `reload`=0 → `count` 3,3(start cycle),2,1,0. `done`=1 for one cycle with `count`=0; `busy` then 0.
- **Tick gating:** `v`=4, `en` pattern 1,0,0,1,1,0,1 → `count` 3,3,3,2,1,1,0. `done` pulses once.
- **Auto-reload:** `v`=2, `reload`=1, `en`=1 for 8 cycles after `start` → `count` 1,2,1,2,… with `done` every 2 cycles. Clearing `reload` before a terminal → stops at 0 in IDLE.
- **Pause and abort:** `v`=10, run to `count`=5, `stop`+`en` together → `count` stays 5 in HOLD for 4 cycles with `en`=1. `start` → resumes at 4 the following tick. Second `stop` in HOLD → IDLE with `count`=5 and no `done`.
- **Boundaries:**
  - `v`=255 counts 255 ticks to `done`.
  - `ld` `v`=7 at `count`=2 mid-run → IDLE, `count`=7, no `done`.
  - `rst` at `count`=1 with `en`=1 → `count`=0, `done` stays 0.
  - `start` with `count`=0 → no state change.
